// File: rtl/regfile_pkg.sv
// Shared helpers for the regfile_sb register file: address-width derivation,
// population count and the default zero-register setting.
package regfile_pkg;

  localparam int unsigned POPCNT_MAX       = 256;
  localparam bit          ZERO_REG_DEFAULT = 1'b1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Keeps the address bus at least one bit wide.
  function automatic int unsigned addr_w(input int unsigned n_regs);
    return (clog2(n_regs) < 1) ? 1 : clog2(n_regs);
  endfunction

  function automatic int unsigned popcount(input logic [POPCNT_MAX-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POPCNT_MAX; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: busy bits, reserve legality, rsv_err and busy count.
// REGFILE_BYPASS_EN: busy_view_c also reflects same-cycle clears.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter bit          ZERO_REG = ZERO_REG_DEFAULT,
  localparam int unsigned AW      = addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REGS-1:0] clr_i,
  input  logic                rsv_en_i,
  input  logic                rsv_pair_i,
  input  logic [AW-1:0]       rsv_addr_i,
  output logic [NUM_REGS-1:0] busy_view_c,
  output logic                rsv_err_o,
  output logic [AW:0]         busy_cnt_o
);

  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

  logic [NUM_REGS-1:0] busy_q, busy_d, set_c;
  logic [AW:0]         cnt_q, cnt_d;
  logic                rsv_err_q, rsv_err_d;
  logic                rsv_illegal;
  logic                conflict;
  logic [AW-1:0]       rsv_addr_nx;

  assign rsv_addr_nx = rsv_addr_i + AW'(1);
  assign rsv_illegal = rsv_pair_i & ((rsv_addr_i == LAST) | (ZERO_REG & (rsv_addr_i == '0)));

  // Bits targeted by a legal reservation; register 0 is never marked when hardwired.
  always_comb begin
    set_c = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (rsv_en_i & ~rsv_illegal &
          ((AW'(i) == rsv_addr_i) | (rsv_pair_i & (AW'(i) == rsv_addr_nx))))
        set_c[i] = 1'b1;
    end
    if (ZERO_REG) set_c[0] = 1'b0;
  end

  // Reserve wins over a same-cycle write clear.
  assign busy_d    = (busy_q & ~clr_i) | set_c;
  assign conflict  = |(set_c & busy_q & ~clr_i);
  assign rsv_err_d = rsv_en_i & (rsv_illegal | conflict);
  assign cnt_d     = (AW+1)'(popcount(POPCNT_MAX'(busy_d)));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      cnt_q     <= '0;
      rsv_err_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      rsv_err_q <= rsv_err_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign busy_view_c = busy_q & ~(clr_i & ~set_c);
`else
  assign busy_view_c = busy_q;
`endif

  assign rsv_err_o  = rsv_err_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with paired access and write-pending scoreboard.
// REGFILE_BYPASS_EN: same-cycle forwarding of the in-flight write to read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 3,
  parameter bit          ZERO_REG = ZERO_REG_DEFAULT,
  localparam int unsigned AW      = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD*DATA_W-1:0] rd_data_hi,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic                     wr_pair,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W-1:0]        wr_data_hi,
  input  logic                     rsv_en,
  input  logic                     rsv_pair,
  input  logic [AW-1:0]            rsv_addr,
  output logic                     wr_err,
  output logic                     rsv_err,
  output logic [AW:0]              busy_cnt
);

  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   rd_src [NUM_REGS];
  logic [NUM_REGS-1:0] we_c;
  logic [NUM_REGS-1:0] busy_view_c;
  logic [AW-1:0]       wr_addr_nx;
  logic                wr_illegal;
  logic                wr_err_q;

  assign wr_addr_nx = wr_addr + AW'(1);
  assign wr_illegal = wr_pair & ((wr_addr == LAST) | (ZERO_REG & (wr_addr == '0)));

  // Per-register write enables and next array contents.
  always_comb begin
    we_c = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (wr_en & ~wr_illegal &
          ((AW'(i) == wr_addr) | (wr_pair & (AW'(i) == wr_addr_nx))))
        we_c[i] = 1'b1;
    end
    if (ZERO_REG) we_c[0] = 1'b0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      regs_d[i] = regs_q[i];
      if (we_c[i]) regs_d[i] = (AW'(i) == wr_addr) ? wr_data : wr_data_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      wr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= regs_d[i];
      wr_err_q <= wr_en & wr_illegal;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
`ifdef REGFILE_BYPASS_EN
      rd_src[i] = regs_d[i];
`else
      rd_src[i] = regs_q[i];
`endif
    end
  end

  // Read ports; the high half of the last register reads zero rather than wrapping.
  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    logic [AW-1:0] ra, ra_nx;
    assign ra    = rd_addr[p*AW +: AW];
    assign ra_nx = ra + AW'(1);
    assign rd_data[p*DATA_W +: DATA_W]    = rd_src[ra];
    assign rd_data_hi[p*DATA_W +: DATA_W] = (ra == LAST) ? '0 : rd_src[ra_nx];
    assign rd_busy[p] = busy_view_c[ra];
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (we_c),
    .rsv_en_i    (rsv_en),
    .rsv_pair_i  (rsv_pair),
    .rsv_addr_i  (rsv_addr),
    .busy_view_c (busy_view_c),
    .rsv_err_o   (rsv_err),
    .busy_cnt_o  (busy_cnt)
  );

  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (32 x 32, 3 read ports, zero register).
module tb_regfile_sb;

  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 32;
  localparam int unsigned NRD = 3;
  localparam int unsigned AW  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data, rd_data_hi;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en, wr_pair, rsv_en, rsv_pair;
  logic [AW-1:0]     wr_addr, rsv_addr;
  logic [DW-1:0]     wr_data, wr_data_hi;
  logic              wr_err, rsv_err;
  logic [AW:0]       busy_cnt;

  int n_checks = 0;
  int n_errors = 0;

  regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_hi(rd_data_hi),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_pair(wr_pair), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_data_hi(wr_data_hi), .rsv_en(rsv_en), .rsv_pair(rsv_pair),
    .rsv_addr(rsv_addr), .wr_err(wr_err), .rsv_err(rsv_err), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_pair = 1'b0; rsv_en = 1'b0; rsv_pair = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    rd_addr = {5'(a2), 5'(a1), 5'(a0)};
    #1;
  endtask

  task automatic do_write(input int a, input logic pair, input logic [DW-1:0] d, input logic [DW-1:0] dh);
    wr_en = 1'b1; wr_pair = pair; wr_addr = 5'(a); wr_data = d; wr_data_hi = dh;
  endtask

  task automatic do_rsv(input int a, input logic pair);
    rsv_en = 1'b1; rsv_pair = pair; rsv_addr = 5'(a);
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_addr = '0; rsv_addr = '0;
    wr_data = '0; wr_data_hi = '0;
    idle();
    tick(); tick();
    rst = 1'b0;

    // Reset state
    set_rd(5, 1, 2);
    check("rst_busy_cnt", 64'(busy_cnt), 64'd0);
    check("rst_wr_err", 64'(wr_err), 64'd0);
    check("rst_rsv_err", 64'(rsv_err), 64'd0);
    check("rst_rd0", 64'(rd_data[31:0]), 64'd0);
    check("rst_rd1", 64'(rd_data[63:32]), 64'd0);
    check("rst_rd2", 64'(rd_data[95:64]), 64'd0);
    check("rst_busy", 64'(rd_busy), 64'd0);

    // Single write reg 5
    do_write(5, 1'b0, 32'hDEADBEEF, 32'h0);
    tick(); idle();
    set_rd(5, 1, 2);
    check("wr5_rd0", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("wr5_wr_err", 64'(wr_err), 64'd0);

    // Pair write at 6
    do_write(6, 1'b1, 32'h11111111, 32'h22222222);
    tick(); idle();
    set_rd(6, 7, 5);
    check("pair6_lo", 64'(rd_data[31:0]), 64'h11111111);
    check("pair6_hi", 64'(rd_data_hi[31:0]), 64'h22222222);
    check("pair6_p1", 64'(rd_data[63:32]), 64'h22222222);
    check("pair6_p2hi", 64'(rd_data_hi[95:64]), 64'h11111111);

    // Illegal pair write at last register
    do_write(31, 1'b1, 32'h33333333, 32'h44444444);
    tick(); idle();
    set_rd(31, 0, 30);
    check("pair31_wr_err", 64'(wr_err), 64'd1);
    check("pair31_rd", 64'(rd_data[31:0]), 64'd0);
    check("pair31_hi_nowrap", 64'(rd_data_hi[31:0]), 64'd0);
    check("pair31_r30hi", 64'(rd_data_hi[95:64]), 64'd0);
    tick();
    check("wr_err_one_cycle", 64'(wr_err), 64'd0);

    // Zero register: write and reserve ignored
    do_write(0, 1'b0, 32'hFFFFFFFF, 32'h0);
    tick(); idle();
    set_rd(0, 0, 0);
    check("zero_rd", 64'(rd_data[31:0]), 64'd0);
    check("zero_wr_err", 64'(wr_err), 64'd0);
    do_rsv(0, 1'b0);
    tick(); idle();
    check("zero_rsv_cnt", 64'(busy_cnt), 64'd0);
    check("zero_rsv_err", 64'(rsv_err), 64'd0);
    check("zero_busy", 64'(rd_busy[0]), 64'd0);

    // Pair reserve 8/9
    do_rsv(8, 1'b1);
    tick(); idle();
    set_rd(8, 9, 5);
    check("rsv8_busy", 64'(rd_busy), 64'b011);
    check("rsv8_cnt", 64'(busy_cnt), 64'd2);
    check("rsv8_err", 64'(rsv_err), 64'd0);

    // Re-reserve 9 -> conflict
    do_rsv(9, 1'b0);
    tick(); idle();
    check("rsv9_err", 64'(rsv_err), 64'd1);
    check("rsv9_cnt", 64'(busy_cnt), 64'd2);
    tick();
    check("rsv_err_one_cycle", 64'(rsv_err), 64'd0);

    // Write reg 8 clears its busy bit
    do_write(8, 1'b0, 32'h00000088, 32'h0);
    tick(); idle();
    set_rd(8, 9, 5);
    check("wr8_cnt", 64'(busy_cnt), 64'd1);
    check("wr8_busy", 64'(rd_busy), 64'b010);
    check("wr8_data", 64'(rd_data[31:0]), 64'h88);

    // Same-cycle write and reserve on reg 12
    do_write(12, 1'b0, 32'h0000000C, 32'h0);
    do_rsv(12, 1'b0);
    tick(); idle();
    set_rd(12, 9, 5);
    check("wr_rsv12_data", 64'(rd_data[31:0]), 64'hC);
    check("wr_rsv12_busy", 64'(rd_busy[0]), 64'd1);
    check("wr_rsv12_cnt", 64'(busy_cnt), 64'd2);
    check("wr_rsv12_err", 64'(rsv_err), 64'd0);

    // Same-cycle visibility of a write to reg 4 on port 1
    set_rd(5, 4, 12);
    do_write(4, 1'b0, 32'hA5A5A5A5, 32'h0);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_rd1", 64'(rd_data[63:32]), 64'hA5A5A5A5);
`else
    check("nobypass_rd1", 64'(rd_data[63:32]), 64'd0);
`endif
    tick(); idle();
    #1;
    check("wr4_next_cycle", 64'(rd_data[63:32]), 64'hA5A5A5A5);

    // Illegal pair reserve at last register
    do_rsv(31, 1'b1);
    tick(); idle();
    set_rd(31, 4, 12);
    check("rsv31_err", 64'(rsv_err), 64'd1);
    check("rsv31_cnt", 64'(busy_cnt), 64'd2);
    check("rsv31_busy", 64'(rd_busy[0]), 64'd0);

    // Reset dominates a same-cycle write
    rst = 1'b1;
    do_write(3, 1'b0, 32'h33333333, 32'h0);
    tick(); idle();
    rst = 1'b0;
    set_rd(3, 5, 12);
    check("rst_wr3", 64'(rd_data[31:0]), 64'd0);
    check("rst_reg5", 64'(rd_data[63:32]), 64'd0);
    check("rst_cnt", 64'(busy_cnt), 64'd0);
    check("rst_busy12", 64'(rd_busy[2]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
